// File: rtl/exe_pkg.sv
// Shared EXE-stage definitions: datapath width and barrel-shift type encodings.
package exe_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

endpackage

// File: rtl/shift_core.sv
// Combinational 32-bit shifter: LSL/LSR/ASR/ROR with ARM-style carry-out.
// A zero amount passes data through with carry 0 (no RRX special case).
module shift_core
  import exe_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        sh_type_i,
  input  logic [4:0]        amt_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o
);

  logic [4:0] lsl_idx;
  logic [4:0] rsh_idx;
  logic [5:0] rot_back;

  always_comb begin
    // 32-amt and amt-1, both in range 1..31 / 0..30 whenever amt is nonzero
    lsl_idx  = 5'd0 - amt_i;
    rsh_idx  = amt_i - 5'd1;
    rot_back = 6'd32 - {1'b0, amt_i};
    result_o = data_i;
    carry_o  = 1'b0;
    if (amt_i != 5'd0) begin
      case (sh_type_i)
        SH_LSL: begin
          result_o = data_i << amt_i;
          carry_o  = data_i[lsl_idx];
        end
        SH_LSR: begin
          result_o = data_i >> amt_i;
          carry_o  = data_i[rsh_idx];
        end
        SH_ASR: begin
          result_o = $signed(data_i) >>> amt_i;
          carry_o  = data_i[rsh_idx];
        end
        default: begin
          result_o = (data_i >> amt_i) | (data_i << rot_back);
          carry_o  = data_i[rsh_idx];
        end
      endcase
    end
  end

endmodule

// File: rtl/shift_unit_arbiter.sv
// Two-requester arbiter in front of one shift_core with a registered, ID-tagged response.
// Define SHIFT_ARB_RR_EN for round-robin; otherwise requester 0 has fixed priority.
module shift_unit_arbiter
  import exe_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NREQ-1:0]               req_valid,
  output logic [NREQ-1:0]               req_ready,
  input  logic [NREQ-1:0][DATA_W-1:0]   req_data,
  input  logic [NREQ-1:0][1:0]          req_type,
  input  logic [NREQ-1:0][4:0]          req_amt,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_id,
  output logic [DATA_W-1:0]             rsp_data,
  output logic                          rsp_carry
);

  // Handshake: a request transfers when req_valid[i] & req_ready[i]; a result
  // retires when rsp_valid & rsp_ready. ready never depends on ready downstream
  // of itself, and valid, once raised, is expected to hold with stable operands.

  logic              prio_q, prio_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic              rsp_carry_q, rsp_carry_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic              any_req;
  logic              gnt_idx;
  logic [NREQ-1:0]   gnt;
  logic              free;
  logic              accept;
  logic [DATA_W-1:0] core_result;
  logic              core_carry;

  always_comb begin
    any_req = |req_valid;
    gnt_idx = req_valid[prio_q] ? prio_q : ~prio_q;
    gnt     = '0;
    if (any_req) gnt[gnt_idx] = 1'b1;
    free    = !rsp_valid_q | rsp_ready;
    // rst_n gating keeps req_ready low for the whole reset window
    req_ready = gnt & {NREQ{free & rst_n}};
    accept    = |(req_valid & req_ready);
  end

  shift_core u_shift_core (
    .data_i    (req_data[gnt_idx]),
    .sh_type_i (req_type[gnt_idx]),
    .amt_i     (req_amt[gnt_idx]),
    .result_o  (core_result),
    .carry_o   (core_carry)
  );

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = gnt_idx;
      rsp_data_d  = core_result;
      rsp_carry_d = core_carry;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

`ifdef SHIFT_ARB_RR_EN
  always_comb begin
    prio_d = prio_q;
    if (accept) prio_d = ~gnt_idx;
  end
`else
  always_comb begin
    prio_d = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
    end else begin
      prio_q      <= prio_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;

endmodule
